// File: rtl/spi_pixel_pkg.sv
// Shared opcodes, transaction states and pixel layout for the SPI pixel buffer.
package spi_pixel_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_COUNT = 8'h02;
    localparam logic [7:0] CMD_SHOW  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_PIX_G,
        ST_PIX_R,
        ST_PIX_B,
        ST_COUNT,
        ST_DISCARD
    } state_t;

    // A stored pixel is {G,R,B}; these index the byte lanes of pixel_t.
    localparam int COL_G = 2;
    localparam int COL_R = 1;
    localparam int COL_B = 0;

    typedef logic [2:0][7:0] pixel_t;

endpackage

// File: rtl/spi_pixel_buffer_spi_slave_byte.sv
// Mode-0 SPI slave byte engine: synchronises the pins into clk_i, assembles
// MOSI bytes and shifts the status byte out on MISO during the first byte.
module spi_slave_byte (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       spi_sclk_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    input  logic [7:0] status_i,
    output logic       spi_miso_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       first_byte_o,
    output logic       cs_active_o
);

    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_mosi_sync;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift_in;
    logic [7:0] r_shift_out;
    logic       r_miso;
    logic       r_byte_valid;
    logic [7:0] r_byte;
    logic       r_first_byte;
    logic       r_first;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_active;

    // Bit 2 of each sync chain is only a history tap for edge detection.
    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_active = ~r_cs_sync[1];

    // NOTE: sequential state is assigned only with <=, so every register
    // samples the pre-edge values and ordering inside the block is irrelevant.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sclk_sync  <= '0;
            r_cs_sync    <= '1;
            r_mosi_sync  <= '0;
            r_bit_cnt    <= '0;
            r_shift_in   <= '0;
            r_shift_out  <= '0;
            r_miso       <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_first_byte <= 1'b0;
            r_first      <= 1'b1;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[1:0], spi_sclk_i};
            r_cs_sync    <= {r_cs_sync[1:0], spi_cs_n_i};
            r_mosi_sync  <= {r_mosi_sync[0], spi_mosi_i};
            r_byte_valid <= 1'b0;

            if (!w_cs_active) begin
                r_bit_cnt   <= '0;
                r_first     <= 1'b1;
                r_shift_out <= '0;
                r_miso      <= 1'b0;
            end else if (w_cs_fall) begin
                // Status bit 7 must be on the pin before the first rising edge.
                r_bit_cnt   <= '0;
                r_first     <= 1'b1;
                r_miso      <= status_i[7];
                r_shift_out <= {status_i[6:0], 1'b0};
            end else begin
                if (w_sclk_rise) begin
                    r_shift_in <= {r_shift_in[6:0], r_mosi_sync[1]};
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_valid <= 1'b1;
                        r_byte       <= {r_shift_in[6:0], r_mosi_sync[1]};
                        r_first_byte <= r_first;
                        r_first      <= 1'b0;
                    end
                end
                if (w_sclk_fall) begin
                    r_miso      <= r_shift_out[7];
                    r_shift_out <= {r_shift_out[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso_o   = r_miso;
    assign byte_valid_o = r_byte_valid;
    assign byte_o       = r_byte;
    assign first_byte_o = r_first_byte;
    assign cs_active_o  = w_cs_active;

endmodule

// File: rtl/spi_pixel_buffer.sv
// SPI-programmed GRB frame buffer feeding a WS2812/SK6812 serializer: command
// FSM, inferred dual-port frame RAM, LED count register and frame start logic.
module spi_pixel_buffer
    import spi_pixel_pkg::*;
#(
    parameter  int NUM_LEDS        = 8,
    parameter  int LED_COUNT_RESET = NUM_LEDS - 1,
    localparam int LED_AW          = $clog2(NUM_LEDS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              start_o,
    input  logic              busy_i,
    input  logic [LED_AW-1:0] address_i,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic [LED_AW-1:0] led_count_o
);

    localparam int COUNT_MAX = 2**LED_AW - 1;
    localparam int COUNT_RST = (LED_COUNT_RESET > COUNT_MAX) ? COUNT_MAX : LED_COUNT_RESET;

    logic              w_byte_valid;
    logic [7:0]        w_byte;
    logic              w_first_byte;
    logic              w_cs_active;
    logic [7:0]        w_status;
    logic              w_show_set;
    logic              w_ram_we;
    pixel_t            w_wdata;

    state_t            r_state;
    logic [7:0]        r_wr_idx;
    logic [7:0]        r_g;
    logic [7:0]        r_r;
    logic [LED_AW-1:0] r_led_count;
    logic              r_show_pending;
    logic              r_busy_sync;
    logic              r_start;
    pixel_t            r_rd;
    pixel_t            r_ram [NUM_LEDS];

    assign w_status = {6'b0, r_show_pending, r_busy_sync};

    spi_slave_byte u_spi (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .spi_sclk_i   (spi_sclk_i),
        .spi_cs_n_i   (spi_cs_n_i),
        .spi_mosi_i   (spi_mosi_i),
        .status_i     (w_status),
        .spi_miso_o   (spi_miso_o),
        .byte_valid_o (w_byte_valid),
        .byte_o       (w_byte),
        .first_byte_o (w_first_byte),
        .cs_active_o  (w_cs_active)
    );

    assign w_show_set = w_byte_valid && w_cs_active && w_first_byte
                        && (r_state == ST_CMD) && (w_byte == CMD_SHOW);
    assign w_ram_we   = w_byte_valid && w_cs_active && (r_state == ST_PIX_B)
                        && (int'(r_wr_idx) < NUM_LEDS);

    always_comb begin
        w_wdata        = '0;
        w_wdata[COL_G] = r_g;
        w_wdata[COL_R] = r_r;
        w_wdata[COL_B] = w_byte;
    end

    // Leaving CS inactive returns to IDLE, which drops any partial pixel.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_wr_idx    <= '0;
            r_g         <= '0;
            r_r         <= '0;
            r_led_count <= LED_AW'(COUNT_RST);
        end else if (!w_cs_active) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_CMD;
                ST_CMD: if (w_byte_valid) begin
                    if (!w_first_byte)             r_state <= ST_DISCARD;
                    else if (w_byte == CMD_WRITE)  r_state <= ST_ADDR;
                    else if (w_byte == CMD_COUNT)  r_state <= ST_COUNT;
                    else                           r_state <= ST_DISCARD;
                end
                ST_ADDR: if (w_byte_valid) begin
                    r_wr_idx <= w_byte;
                    r_state  <= ST_PIX_G;
                end
                ST_PIX_G: if (w_byte_valid) begin
                    r_g     <= w_byte;
                    r_state <= ST_PIX_R;
                end
                ST_PIX_R: if (w_byte_valid) begin
                    r_r     <= w_byte;
                    r_state <= ST_PIX_B;
                end
                ST_PIX_B: if (w_byte_valid) begin
                    if (r_wr_idx != 8'hFF) r_wr_idx <= r_wr_idx + 8'd1;
                    r_state <= ST_PIX_G;
                end
                ST_COUNT: if (w_byte_valid) begin
                    if (w_byte != 8'd0) begin
                        r_led_count <= (int'(w_byte) > COUNT_MAX) ? LED_AW'(COUNT_MAX)
                                                                  : w_byte[LED_AW-1:0];
                    end
                    r_state <= ST_DISCARD;
                end
                ST_DISCARD: r_state <= ST_DISCARD;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the frame RAM has no reset so it maps onto block RAM; only the
    // read register below is cleared.
    always_ff @(posedge clk_i) begin
        if (w_ram_we) r_ram[r_wr_idx[LED_AW-1:0]] <= w_wdata;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)                          r_rd <= '0;
        else if (int'(address_i) < NUM_LEDS)  r_rd <= r_ram[address_i];
        else                                  r_rd <= '0;
    end

    // A SHOW landing in the same cycle as the launch re-arms show_pending.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_start        <= 1'b0;
            r_show_pending <= 1'b0;
            r_busy_sync    <= 1'b0;
        end else begin
            r_busy_sync <= busy_i;
            if (r_show_pending && !busy_i) begin
                r_start        <= 1'b1;
                r_show_pending <= w_show_set;
            end else begin
                r_start <= 1'b0;
                if (w_show_set) r_show_pending <= 1'b1;
            end
        end
    end

    assign start_o     = r_start;
    assign red_o       = r_rd[COL_R];
    assign green_o     = r_rd[COL_G];
    assign blue_o      = r_rd[COL_B];
    assign led_count_o = r_led_count;

endmodule

// File: tb/tb_spi_pixel_buffer.sv
// Scoreboard bench for spi_pixel_buffer: an SPI host drives directed and random
// frames while monitors compare reads, LED count, MISO bytes and start pulses.
module tb_spi_pixel_buffer;
    import spi_pixel_pkg::*;

    localparam int NUM_LEDS = 8;
    localparam int LED_AW   = 3;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              busy = 1'b0;
    logic [LED_AW-1:0] address = '0;
    logic              miso;
    logic              start;
    logic [7:0]        red, green, blue;
    logic [LED_AW-1:0] led_count;

    spi_pixel_buffer #(.NUM_LEDS(NUM_LEDS)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .spi_sclk_i  (sclk),
        .spi_cs_n_i  (cs_n),
        .spi_mosi_i  (mosi),
        .spi_miso_o  (miso),
        .start_o     (start),
        .busy_i      (busy),
        .address_i   (address),
        .red_o       (red),
        .green_o     (green),
        .blue_o      (blue),
        .led_count_o (led_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: frame contents as {G,R,B}, LED count and SHOW state.
    logic [23:0] model_ram [NUM_LEDS];
    bit          model_known [NUM_LEDS];
    int          model_count = NUM_LEDS - 1;
    bit          model_pending = 1'b0;

    // Scoreboard queues.
    logic [23:0] rd_exp_q [$];
    int          cnt_exp_q [$];
    logic [7:0]  miso_exp_q [$];
    logic [7:0]  miso_obs_q [$];
    int          start_exp = 0;

    logic rd_req = 1'b0, rd_req_q = 1'b0;
    logic cnt_req = 1'b0, cnt_req_q = 1'b0;

    always @(posedge clk) begin
        rd_req_q  <= rd_req;
        cnt_req_q <= cnt_req;
    end

    always @(negedge clk) begin
        if (rd_req_q && rd_exp_q.size() > 0)
            check("pixel_read", {8'h0, green, red, blue}, {8'h0, rd_exp_q.pop_front()});
        if (cnt_req_q && cnt_exp_q.size() > 0)
            check("led_count", 32'(led_count), 32'(cnt_exp_q.pop_front()));
        while (miso_obs_q.size() > 0 && miso_exp_q.size() > 0)
            check("miso_byte", 32'(miso_obs_q.pop_front()), 32'(miso_exp_q.pop_front()));
        if (start) begin
            if (start_exp > 0) start_exp--;
            else check("start_unexpected", 32'(start), 32'd0);
        end
    end

    // ---------------- SPI host ----------------
    logic [7:0] tx_q [$];

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            r[i] = miso;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic model_post();
        int idx;
        if (tx_q[0] == CMD_WRITE && tx_q.size() >= 2) begin
            idx = int'(tx_q[1]);
            for (int k = 2; k + 2 < tx_q.size(); k += 3) begin
                if (idx < NUM_LEDS) begin
                    model_ram[idx]   = {tx_q[k], tx_q[k+1], tx_q[k+2]};
                    model_known[idx] = 1'b1;
                end
                if (idx < 255) idx++;
            end
        end else if (tx_q[0] == CMD_COUNT && tx_q.size() >= 2 && tx_q[1] != 8'd0) begin
            model_count = (int'(tx_q[1]) > NUM_LEDS - 1) ? NUM_LEDS - 1 : int'(tx_q[1]);
        end
    endtask

    task automatic spi_frame();
        logic [7:0] r;
        foreach (tx_q[i]) miso_exp_q.push_back(i == 0 ? {6'b0, model_pending, busy} : 8'h00);
        if (tx_q[0] == CMD_SHOW) begin
            if (!busy) start_exp++;
            else model_pending = 1'b1;
        end
        cs_low();
        foreach (tx_q[i]) begin
            spi_byte(tx_q[i], r);
            miso_obs_q.push_back(r);
        end
        cs_high();
        model_post();
    endtask

    task automatic set_busy(input logic b);
        @(negedge clk);
        if (!b && model_pending) begin
            start_exp++;
            model_pending = 1'b0;
        end
        busy = b;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 60 && start_exp > 0; i++) @(negedge clk);
        check("start_pulse_seen", 32'(start_exp), 32'd0);
    endtask

    task automatic read_px(input int a, input logic [23:0] exp);
        @(negedge clk);
        address = LED_AW'(a);
        rd_exp_q.push_back(exp);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < NUM_LEDS; a++)
            if (model_known[a]) read_px(a, model_ram[a]);
    endtask

    task automatic check_count();
        @(negedge clk);
        cnt_exp_q.push_back(model_count);
        cnt_req = 1'b1;
        @(negedge clk);
        cnt_req = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int         n;
        repeat (3) @(negedge clk);
        // Outputs while reset is held.
        for (int a = 0; a < NUM_LEDS; a++) read_px(a, 24'h0);
        check_count();
        check("reset_start", 32'(start), 32'd0);
        check("reset_miso", 32'(miso), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        repeat (5) @(negedge clk);

        tx_q = '{8'h01, 8'h00, 8'h5A, 8'hA5, 8'h3C};
        spi_frame();
        tx_q = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        spi_frame();
        read_all();
        read_px(3, {8'h44, 8'h55, 8'h66});

        tx_q = '{8'h02, 8'h05}; spi_frame(); check_count();
        tx_q = '{8'h02, 8'h00}; spi_frame(); check_count();
        tx_q = '{8'h02, 8'hFF}; spi_frame(); check_count();

        tx_q = '{CMD_SHOW}; spi_frame(); wait_start();
        repeat (20) @(negedge clk);
        set_busy(1'b1);
        repeat (5) @(negedge clk);
        tx_q = '{CMD_SHOW}; spi_frame();
        repeat (30) @(negedge clk);
        tx_q = '{CMD_SHOW, 8'h00}; spi_frame();
        repeat (20) @(negedge clk);
        set_busy(1'b0);
        wait_start();
        repeat (30) @(negedge clk);
        tx_q = '{8'h00, 8'h00}; spi_frame();

        tx_q = '{8'h01, 8'h07, 8'hAA, 8'hBB, 8'hCC, 8'hDD}; spi_frame();
        read_px(7, 24'hAABBCC);
        tx_q = '{8'h01, 8'h07, 8'h12, 8'h34, 8'h56, 8'h9A, 8'hBC, 8'hDE}; spi_frame();
        read_all();

        // Reset in the middle of a pixel, then a clean transaction.
        cs_low();
        spi_byte(8'h01, r);
        spi_byte(8'h00, r);
        spi_byte(8'h77, r);
        @(negedge clk);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        model_count = NUM_LEDS - 1;
        model_pending = 1'b0;
        check_count();
        tx_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03}; spi_frame();
        read_px(0, 24'h010203);

        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    tx_q = '{CMD_WRITE, ($urandom_range(0, 7) == 0) ? 8'($urandom_range(250, 255))
                                                                   : 8'($urandom_range(0, 9))};
                    n = 3 * $urandom_range(1, 4) + $urandom_range(0, 2);
                    for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
                end
                2: begin
                    case ($urandom_range(0, 2))
                        0:       tx_q = '{CMD_COUNT, 8'h00};
                        1:       tx_q = '{CMD_COUNT, 8'($urandom_range(1, 7))};
                        default: tx_q = '{CMD_COUNT, 8'($urandom_range(8, 255))};
                    endcase
                end
                default: tx_q = '{8'($urandom_range(4, 255)), 8'($urandom), 8'($urandom)};
            endcase
            spi_frame();
            read_all();
            check_count();
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drain", 32'(rd_exp_q.size() + cnt_exp_q.size() + miso_exp_q.size()), 32'd0);
        check("start_outstanding", 32'(start_exp), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_pixel_buffer.md
Name: spi_pixel_buffer

Overview:
SPI-slave front end and pixel frame buffer that sits directly upstream of the WS2812/SK6812 serializer. It receives commands and pixel bytes from the host over mode-0 SPI and stores GRB pixels in an internal dual-port RAM. It serves the serializer's address-driven colour reads, programs the active LED count, and issues the start pulse that launches a frame refresh.

Parameters:
NUM_LEDS, 8, frame buffer depth in LEDs; must be ≤256. LED_AW = $clog2(NUM_LEDS) is derived from it.
LED_COUNT_RESET, NUM_LEDS-1, reset value of led_count_o; saturated to 2^LED_AW-1.

Ports:
clk_i  in  1  system clock (50 MHz nominal)
reset_i  in  1  synchronous, active-high reset
spi_sclk_i  in  1  SPI clock, asynchronous; idles low (mode 0); f_sclk ≤ f_clk/8
spi_cs_n_i  in  1  SPI chip select, active low, asynchronous
spi_mosi_i  in  1  SPI data in, asynchronous
spi_miso_o  out  1  SPI data out; external tristate is gated by cs_n
start_o  out  1  one-cycle frame start pulse to the serializer
busy_i  in  1  serializer busy, high while a frame is being sent
address_i  in  LED_AW  LED index requested by the serializer
red_o, green_o, blue_o  out  8 each  pixel colour at address_i
led_count_o  out  LED_AW  number of LEDs to drive

Behaviour:
- Reset values: spi_miso_o=0, start_o=0, red_o/green_o/blue_o=0, led_count_o=LED_COUNT_RESET, show_pending=0. Frame RAM contents are not reset.
- Input synchronisation: sclk, cs_n and mosi each pass through 2-FF synchronisers. Edges are detected on the synchronised sclk. MOSI is sampled on the rising edge, MSB first. MISO updates on the falling edge.
- Byte assembly:
  - A bit counter clears on the cs_n falling edge.
  - On the 8th rising edge, a one-cycle byte_valid pulse is generated together with the byte value and a first_byte flag.
  - cs_n high clears the counters and the command state. A partial byte is discarded.
- Transaction FSM, state per CS frame: IDLE -> CMD -> (ADDR -> PIX_G -> PIX_R -> PIX_B -> PIX_G ...) | COUNT | DISCARD.
  - Byte 0 is the opcode: 0x01 WRITE -> ADDR; 0x02 COUNT -> COUNT; 0x03 SHOW sets show_pending and then -> DISCARD; any other opcode -> DISCARD.
  - ADDR: the byte loads the write index wr_idx (8 bits).
  - PIX_G / PIX_R / PIX_B: G and R are latched. On B, RAM[wr_idx] <= {G,R,B} and wr_idx increments. The index saturates at 255, so it does not wrap.
  - Any write with wr_idx ≥ NUM_LEDS is dropped silently.
  - cs_n rising in PIX_G or PIX_R drops the pending partial pixel.
  - COUNT: byte value 0 is ignored. Values above 2^LED_AW-1 saturate. Otherwise led_count_o <= byte in the cycle after byte_valid. Further bytes are discarded.
  - DISCARD: all bytes are ignored until cs_n rises.
- MISO: during byte 0, the status byte {6'b0, show_pending, busy_sync} is shifted out MSB first. It is captured on the cs_n falling edge. All later bytes return 0x00.
- Read port:
  - red/green/blue_o are registered from RAM[address_i], giving one-cycle latency.
  - The serializer holds address_i stable for ≥2 cycles before sampling.
  - address_i ≥ NUM_LEDS returns 0.
  - A same-cycle write and read at the same address returns the old data (read-first).
- Start logic: start_o pulses high for exactly one cycle when show_pending=1 and busy_i=0. show_pending clears in the same cycle.
  - SHOW while busy_i=1 stays pending until busy_i falls.
  - Multiple SHOWs while pending coalesce into one pulse.
  - A SHOW arriving in the same cycle that clears a pending SHOW produces a second pending SHOW.
- reset_i mid-transaction aborts the FSM. The host must deassert cs_n before the next command.

Decomposition:
- Package spi_pixel_pkg holds:
  - opcode constants: CMD_WRITE=8'h01, CMD_COUNT=8'h02, CMD_SHOW=8'h03;
  - the FSM state enum;
  - the colour index constants G/R/B.
- Submodule spi_slave_byte contains the synchronisers, edge detect, shift-in, shift-out, byte_valid, first_byte and cs_active outputs.
- The top level contains the command FSM, the frame RAM (inferred, 24 bits × NUM_LEDS) and the start logic.

Test Plan:
- Reset, then read address_i=0..7 -> RGB=0, led_count_o=7, start_o=0, spi_miso_o=0.
- SPI 01 02 11 22 33 44 55 66 (sclk = clk/10) -> RAM[2]={G11,R22,B33}, RAM[3]={G44,R55,B66}; reading address_i=3 gives red_o=55, green_o=44, blue_o=66 one cycle later.
- SPI 02 05 -> led_count_o=5. SPI 02 00 -> led_count_o unchanged. SPI 02 FF with NUM_LEDS=8 -> led_count_o=7.
- SPI 03 with busy_i=0 -> a single start_o pulse of 1 cycle. SPI 03 with busy_i=1 -> no pulse; busy_i falls -> exactly one pulse; the MISO status byte during a second opcode reads 0x03.
- SPI 01 07 AA BB CC DD then cs_n rises -> RAM[7]={AA,BB,CC}; the partial pixel DD is dropped; RAM[0] is untouched (no wrap).
- Assert reset_i mid-pixel, then run a new transaction 01 00 01 02 03 -> RAM[0]={01,02,03}, with no stale state.
